// File: rtl/cache_axi_rd_bridge_pkg.sv
// Shared codes and state encoding for the cache miss-read AXI bridge.
// Request types, AXI constants and line geometry defaults.
package cache_axi_rd_bridge_pkg;

   localparam logic [2:0] RD_TYPE_BYTE = 3'b000;
   localparam logic [2:0] RD_TYPE_HALF = 3'b001;
   localparam logic [2:0] RD_TYPE_WORD = 3'b010;
   localparam logic [2:0] RD_TYPE_LINE = 3'b100;

   localparam int DEF_LINE_WORDS = 4;
   localparam int DEF_OFFLEN     = 4;

   localparam logic [1:0] AXI_BURST_INCR = 2'b01;
   localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
   localparam logic [2:0] AXI_SIZE_WORD  = 3'b010;

   typedef enum logic [2:0] {
      ST_IDLE = 3'b001,
      ST_AR   = 3'b010,
      ST_R    = 3'b100
   } state_t;

endpackage

// File: rtl/cache_axi_rd_bridge.sv
// Cache miss-read responder: one AXI4 read burst per request,
// R beats streamed back to the cache one cycle after acceptance.
module cache_axi_rd_bridge
   import cache_axi_rd_bridge_pkg::*;
#(
   parameter logic [3:0] ARID       = 4'd0,
   parameter int         LINE_WORDS = DEF_LINE_WORDS,
   parameter int         OFFLEN     = DEF_OFFLEN
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        rd_req,
   input  logic [2:0]  rd_type,
   input  logic [31:0] rd_addr,
   output logic        rd_rdy,
   output logic        ret_valid,
   output logic        ret_last,
   output logic [31:0] ret_data,
   output logic [3:0]  arid,
   output logic [31:0] araddr,
   output logic [7:0]  arlen,
   output logic [2:0]  arsize,
   output logic [1:0]  arburst,
   output logic        arvalid,
   input  logic        arready,
   input  logic [3:0]  rid,
   input  logic [31:0] rdata,
   input  logic [1:0]  rresp,
   input  logic        rlast,
   input  logic        rvalid,
   output logic        rready,
   output logic        err
);

   localparam logic [31:0] LINE_MASK = ~((32'd1 << OFFLEN) - 32'd1);
   localparam logic [7:0]  LINE_LEN  = 8'(LINE_WORDS - 1);

   state_t      state_q;
   state_t      state_d;
   logic [7:0]  cnt_q;
   logic        rd_hs;
   logic        ar_hs;
   logic        beat;
   logic        beat_err;

   assign rd_rdy  = (state_q == ST_IDLE);
   assign arvalid = (state_q == ST_AR);
   assign rready  = (state_q == ST_R);

   assign rd_hs = rd_req && rd_rdy;
   assign ar_hs = arvalid && arready;
   assign beat  = rvalid && rready;

   // Burst-shape checks use the count before this beat is added.
   assign beat_err = (rresp != AXI_RESP_OKAY)
                  || (rid != ARID)
                  || (rlast && (cnt_q != arlen))
                  || (!rlast && (cnt_q == arlen));

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (1'b1)
         state_q[0]: if (rd_hs) state_d = ST_AR;
         state_q[1]: if (ar_hs) state_d = ST_R;
         state_q[2]: if (beat && rlast) state_d = ST_IDLE;
         default:    state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         arid    <= '0;
         araddr  <= '0;
         arlen   <= '0;
         arsize  <= '0;
         arburst <= '0;
      end else if (rd_hs) begin
         arid    <= ARID;
         arburst <= AXI_BURST_INCR;
         if (rd_type == RD_TYPE_LINE) begin
            araddr <= rd_addr & LINE_MASK;
            arlen  <= LINE_LEN;
            arsize <= AXI_SIZE_WORD;
         end else begin
            araddr <= rd_addr;
            arlen  <= 8'd0;
            arsize <= {1'b0, rd_type[1:0]};
         end
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         cnt_q <= '0;
      end else if (ar_hs) begin
         cnt_q <= '0;
      end else if (beat) begin
         cnt_q <= cnt_q + 8'd1;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         ret_valid <= 1'b0;
         ret_last  <= 1'b0;
         ret_data  <= '0;
      end else begin
         ret_valid <= beat;
         ret_last  <= beat && rlast;
         if (beat) ret_data <= rdata;
      end
   end

   // Sticky until reset; a bad beat still returns its data.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         err <= 1'b0;
      end else if (beat && beat_err) begin
         err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_cache_axi_rd_bridge.sv
// Directed bench for cache_axi_rd_bridge: line/byte/word reads,
// AR stall, R gaps, early rlast and mid-burst reset.
module tb_cache_axi_rd_bridge;

   logic        clk;
   logic        resetn;
   logic        rd_req;
   logic [2:0]  rd_type;
   logic [31:0] rd_addr;
   logic        rd_rdy;
   logic        ret_valid;
   logic        ret_last;
   logic [31:0] ret_data;
   logic [3:0]  arid;
   logic [31:0] araddr;
   logic [7:0]  arlen;
   logic [2:0]  arsize;
   logic [1:0]  arburst;
   logic        arvalid;
   logic        arready;
   logic [3:0]  rid;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rlast;
   logic        rvalid;
   logic        rready;
   logic        err;

   int n_run;
   int n_fail;

   cache_axi_rd_bridge dut (
      .clk(clk), .resetn(resetn),
      .rd_req(rd_req), .rd_type(rd_type), .rd_addr(rd_addr),
      .rd_rdy(rd_rdy),
      .ret_valid(ret_valid), .ret_last(ret_last), .ret_data(ret_data),
      .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
      .arburst(arburst), .arvalid(arvalid), .arready(arready),
      .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
      .rvalid(rvalid), .rready(rready), .err(err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_run++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Presents one R beat for a single cycle, then checks the return.
   task automatic send_beat(input string tag, input logic [31:0] d,
                            input logic last);
      rvalid = 1'b1;
      rdata  = d;
      rlast  = last;
      step();
      rvalid = 1'b0;
      rlast  = 1'b0;
      chk({tag, "_rv"}, 32'(ret_valid), 32'd1);
      chk({tag, "_rd"}, ret_data, d);
      chk({tag, "_rl"}, 32'(ret_last), 32'(last));
   endtask

   task automatic issue(input logic [2:0] t, input logic [31:0] a);
      rd_req  = 1'b1;
      rd_type = t;
      rd_addr = a;
      step();
      rd_req  = 1'b0;
   endtask

   initial begin
      n_run   = 0;
      n_fail  = 0;
      resetn  = 1'b0;
      rd_req  = 1'b0;
      rd_type = 3'd0;
      rd_addr = 32'd0;
      arready = 1'b0;
      rid     = 4'd0;
      rdata   = 32'd0;
      rresp   = 2'b00;
      rlast   = 1'b0;
      rvalid  = 1'b0;
      step();
      step();
      chk("rst_rd_rdy", 32'(rd_rdy), 32'd1);
      chk("rst_arvalid", 32'(arvalid), 32'd0);
      chk("rst_rready", 32'(rready), 32'd0);
      chk("rst_ret_valid", 32'(ret_valid), 32'd0);
      chk("rst_ret_data", ret_data, 32'd0);
      chk("rst_err", 32'(err), 32'd0);
      chk("rst_araddr", araddr, 32'd0);
      chk("rst_arburst", 32'(arburst), 32'd0);
      resetn = 1'b1;
      step();

      // Line read
      arready = 1'b1;
      issue(3'b100, 32'h1C00_0024);
      chk("ln_arvalid", 32'(arvalid), 32'd1);
      chk("ln_rd_rdy", 32'(rd_rdy), 32'd0);
      chk("ln_araddr", araddr, 32'h1C00_0020);
      chk("ln_arlen", 32'(arlen), 32'd3);
      chk("ln_arsize", 32'(arsize), 32'd2);
      chk("ln_arburst", 32'(arburst), 32'd1);
      chk("ln_arid", 32'(arid), 32'd0);
      step();
      chk("ln_rready", 32'(rready), 32'd1);
      chk("ln_arvalid_off", 32'(arvalid), 32'd0);
      send_beat("ln_b0", 32'hA0, 1'b0);
      send_beat("ln_b1", 32'hA1, 1'b0);
      send_beat("ln_b2", 32'hA2, 1'b0);
      send_beat("ln_b3", 32'hA3, 1'b1);
      chk("ln_rd_rdy_end", 32'(rd_rdy), 32'd1);
      chk("ln_err", 32'(err), 32'd0);

      // Byte read, issued in the bubble cycle after the line rlast
      issue(3'b000, 32'h0000_1003);
      chk("by_araddr", araddr, 32'h0000_1003);
      chk("by_arlen", 32'(arlen), 32'd0);
      chk("by_arsize", 32'(arsize), 32'd0);
      step();
      send_beat("by_b0", 32'h0000_00B7, 1'b1);
      chk("by_rd_rdy", 32'(rd_rdy), 32'd1);
      chk("by_err", 32'(err), 32'd0);

      // Stray R traffic in IDLE is ignored
      rvalid = 1'b1;
      rlast  = 1'b1;
      rresp  = 2'b10;
      rdata  = 32'hDEAD;
      step();
      rvalid = 1'b0;
      rlast  = 1'b0;
      rresp  = 2'b00;
      chk("idle_rv_ret", 32'(ret_valid), 32'd0);
      chk("idle_rv_err", 32'(err), 32'd0);

      // AR stall: payload stable, second request refused
      arready = 1'b0;
      issue(3'b010, 32'h2000_0008);
      rd_req  = 1'b1;
      rd_type = 3'b100;
      rd_addr = 32'h3000_0000;
      for (int i = 0; i < 5; i++) begin
         chk("st_arvalid", 32'(arvalid), 32'd1);
         chk("st_rd_rdy", 32'(rd_rdy), 32'd0);
         chk("st_araddr", araddr, 32'h2000_0008);
         chk("st_arlen", 32'(arlen), 32'd0);
         chk("st_arsize", 32'(arsize), 32'd2);
         step();
      end
      rd_req  = 1'b0;
      arready = 1'b1;
      chk("st_arvalid_hold", 32'(arvalid), 32'd1);
      step();
      chk("st_rready", 32'(rready), 32'd1);
      send_beat("st_b0", 32'hC0C0_C0C0, 1'b1);

      // Line burst with rvalid gaps: beats on cycles 0,2,3,7
      issue(3'b100, 32'h4000_003C);
      chk("gp_araddr", araddr, 32'h4000_0030);
      step();
      send_beat("gp_b0", 32'hD0, 1'b0);
      step();
      chk("gp_gap1", 32'(ret_valid), 32'd0);
      send_beat("gp_b1", 32'hD1, 1'b0);
      send_beat("gp_b2", 32'hD2, 1'b0);
      for (int i = 0; i < 3; i++) begin
         step();
         chk("gp_gap2", 32'(ret_valid), 32'd0);
      end
      send_beat("gp_b3", 32'hD3, 1'b1);
      chk("gp_err", 32'(err), 32'd0);

      // Early rlast on beat 2 of a line
      issue(3'b100, 32'h0000_0100);
      step();
      send_beat("er_b0", 32'hE0, 1'b0);
      send_beat("er_b1", 32'hE1, 1'b1);
      chk("er_err", 32'(err), 32'd1);
      chk("er_idle", 32'(rd_rdy), 32'd1);
      issue(3'b010, 32'h0000_0104);
      chk("er_nx_araddr", araddr, 32'h0000_0104);
      step();
      send_beat("er_nx", 32'hF0, 1'b1);
      chk("er_sticky", 32'(err), 32'd1);

      // Reset pulsed during beat 2 of a line burst
      issue(3'b100, 32'h0000_0200);
      step();
      send_beat("rs_b0", 32'h0000_0099, 1'b0);
      rvalid = 1'b1;
      rdata  = 32'h0000_0098;
      #2;
      resetn = 1'b0;
      #1;
      chk("rs_rd_rdy", 32'(rd_rdy), 32'd1);
      chk("rs_rready", 32'(rready), 32'd0);
      chk("rs_ret_valid", 32'(ret_valid), 32'd0);
      chk("rs_ret_data", ret_data, 32'd0);
      chk("rs_err", 32'(err), 32'd0);
      chk("rs_araddr", araddr, 32'd0);
      rvalid = 1'b0;
      step();
      resetn = 1'b1;
      step();
      issue(3'b010, 32'h0000_0300);
      chk("rs_nx_araddr", araddr, 32'h0000_0300);
      chk("rs_nx_arsize", 32'(arsize), 32'd2);
      step();
      send_beat("rs_nx", 32'h1234_5678, 1'b1);
      chk("rs_nx_err", 32'(err), 32'd0);
      chk("rs_nx_rdy", 32'(rd_rdy), 32'd1);

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
